// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter feeding a shared syn_fifo, with burst limiting,
// credit-based back-pressure (level) and a sticky FIFO error flag.
module fifo_wr_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_SIZE  = 16,
    parameter int MAX_BURST  = 4,
    parameter int CNT_W      = $clog2(FIFO_SIZE) + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wdata,
    input  logic                          fifo_rd_en,
    input  logic                          fifo_empty,
    input  logic                          fifo_full,
    input  logic                          fifo_overflow,
    output logic [CNT_W-1:0]              level,
    output logic                          err
);

    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BCNT_W = $clog2(MAX_BURST + 1);

    localparam logic [CNT_W-1:0]  LVL_MAX   = CNT_W'(FIFO_SIZE);
    localparam logic [CNT_W-1:0]  LVL_WARN  = CNT_W'(FIFO_SIZE - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(1'b0);
    localparam logic [BCNT_W-1:0] BCNT_MAX  = BCNT_W'(MAX_BURST);
    localparam logic [BCNT_W-1:0] BCNT_ONE  = BCNT_W'(1'b1);
    localparam logic [BCNT_W-1:0] BCNT_ZERO = BCNT_W'(1'b0);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(NUM_REQ - 1);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1'b1);
    localparam logic [PTR_W-1:0]  PTR_ZERO  = PTR_W'(1'b0);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                  state_r, state_nxt_s;
    logic [PTR_W-1:0]        rr_ptr_r, rr_ptr_nxt_s;
    logic [PTR_W-1:0]        owner_r, owner_nxt_s;
    logic [PTR_W-1:0]        gnt_idx_s;
    logic [BCNT_W-1:0]       bcnt_r, bcnt_nxt_s;
    logic [CNT_W-1:0]        level_r;
    logic                    err_r;
    logic                    wr_en_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic [NUM_REQ-1:0]      gnt_s;
    logic [PTR_W:0]          pick_s;
    logic                    credit_ok_s;
    logic                    accept_s;
    logic                    drain_s;

    // Returns {valid, index} of the first requester at or after ptr (wrapping).
    // Scanning from the far end lets the nearest hit overwrite earlier ones.
    function automatic logic [PTR_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [PTR_W-1:0]   ptr);
        logic [PTR_W:0]   res;
        logic [PTR_W-1:0] cand;
        res = {(PTR_W+1){1'b0}};
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = PTR_W'((int'(ptr) + k) % NUM_REQ);
            if (r[cand]) begin
                res = {1'b1, cand};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign credit_ok_s = (level_r < LVL_MAX) && !fifo_full;
    assign gnt         = gnt_s & {NUM_REQ{rst}};
    assign accept_s    = |(gnt & req);
    assign drain_s     = fifo_rd_en && !fifo_empty;

    // Next-state and grant decode; a burst release cycle never grants.
    always_comb begin
        state_nxt_s  = state_r;
        rr_ptr_nxt_s = rr_ptr_r;
        owner_nxt_s  = owner_r;
        bcnt_nxt_s   = bcnt_r;
        gnt_idx_s    = owner_r;
        gnt_s        = {NUM_REQ{1'b0}};
        pick_s       = rr_pick(req, rr_ptr_r);
        case (state_r)
            IDLE: begin
                if (credit_ok_s && pick_s[PTR_W]) begin
                    gnt_idx_s               = pick_s[PTR_W-1:0];
                    gnt_s[pick_s[PTR_W-1:0]] = 1'b1;
                    owner_nxt_s             = pick_s[PTR_W-1:0];
                    bcnt_nxt_s              = BCNT_ONE;
                    state_nxt_s             = BURST;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BURST: begin
                if (!req[owner_r] || (bcnt_r == BCNT_MAX)) begin
                    state_nxt_s  = IDLE;
                    rr_ptr_nxt_s = (owner_r == PTR_LAST) ? PTR_ZERO : owner_r + PTR_ONE;
                    bcnt_nxt_s   = BCNT_ZERO;
                end else if (credit_ok_s) begin
                    gnt_s[owner_r] = 1'b1;
                    bcnt_nxt_s     = bcnt_r + BCNT_ONE;
                end else begin
                    state_nxt_s = BURST;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= IDLE;
            rr_ptr_r <= PTR_ZERO;
            owner_r  <= PTR_ZERO;
            bcnt_r   <= BCNT_ZERO;
        end else begin
            state_r  <= state_nxt_s;
            rr_ptr_r <= rr_ptr_nxt_s;
            owner_r  <= owner_nxt_s;
            bcnt_r   <= bcnt_nxt_s;
        end
    end

    // Credit counter: counts a beat as soon as it is accepted, not when written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_r <= CNT_ZERO;
        end else begin
            case ({accept_s, drain_s})
                2'b10:   level_r <= level_r + CNT_ONE;
                2'b01:   level_r <= (level_r == CNT_ZERO) ? level_r : level_r - CNT_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    // Sticky error: overflow, or FIFO claims full while credit says otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_r <= 1'b0;
        end else if (fifo_overflow || (fifo_full && (level_r < LVL_WARN))) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    // Registered write port toward the FIFO; data holds between beats.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en_r <= 1'b0;
            wdata_r <= {DATA_WIDTH{1'b0}};
        end else begin
            wr_en_r <= accept_s;
            if (accept_s) begin
                wdata_r <= req_data[int'(gnt_idx_s)*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                wdata_r <= wdata_r;
            end
        end
    end

    assign fifo_wr_en = wr_en_r;
    assign fifo_wdata = wdata_r;
    assign level      = level_r;
    assign err        = err_r;

    fifo_wr_arb_chk #(
        .NUM_REQ  (NUM_REQ),
        .FIFO_SIZE(FIFO_SIZE),
        .CNT_W    (CNT_W)
    ) u_chk (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .gnt      (gnt),
        .level    (level_r),
        .fifo_full(fifo_full)
    );

endmodule

// Invariants of the arbiter: grant shape, credit gating and level bound.
module fifo_wr_arb_chk #(
    parameter int NUM_REQ   = 4,
    parameter int FIFO_SIZE = 16,
    parameter int CNT_W     = $clog2(FIFO_SIZE) + 1
) (
    input logic               clk,
    input logic               rst,
    input logic [NUM_REQ-1:0] req,
    input logic [NUM_REQ-1:0] gnt,
    input logic [CNT_W-1:0]   level,
    input logic               fifo_full
);

    localparam logic [CNT_W-1:0] LVL_MAX = CNT_W'(FIFO_SIZE);

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(gnt))
        else $error("gnt not one-hot");
    a_gnt_req: assert property (@(posedge clk) disable iff (!rst) ((gnt & ~req) == {NUM_REQ{1'b0}}))
        else $error("gnt without req");
    a_gnt_credit: assert property (@(posedge clk) disable iff (!rst)
        (|gnt) |-> ((level < LVL_MAX) && !fifo_full))
        else $error("gnt without credit");
    a_level_max: assert property (@(posedge clk) disable iff (!rst) (level <= LVL_MAX))
        else $error("level above FIFO_SIZE");

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Self-checking bench for fifo_wr_arb: directed tables, corner sequences and
// random traffic checked against a queue-based reference model.
module tb_fifo_wr_arb;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int FS = 16;
    localparam int MB = 4;
    localparam int CW = $clog2(FS) + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    gnt;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_wdata;
    logic            fifo_rd_en = 1'b0;
    logic            fifo_empty = 1'b1;
    logic            fifo_full = 1'b0;
    logic            fifo_overflow = 1'b0;
    logic [CW-1:0]   level;
    logic            err;

    fifo_wr_arb #(.NUM_REQ(N), .DATA_WIDTH(DW), .FIFO_SIZE(FS), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
        .fifo_wr_en(fifo_wr_en), .fifo_wdata(fifo_wdata), .fifo_rd_en(fifo_rd_en),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_overflow(fifo_overflow),
        .level(level), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk;
    int n_err;

    // Reference model: burst owner (-1 = arbitrating), beats so far, rr pointer,
    // credit level, expected write port, and the FIFO contents as a queue.
    int            m_owner;
    int            m_beats;
    int            m_ptr;
    int            m_level;
    int            last_acc;
    bit            m_err;
    bit            m_wr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_q[$];
    bit            force_full;
    bit            force_ovf;
    logic [N-1:0]  obs_gnt;

    typedef struct {
        logic [N-1:0] req;
        logic         rd;
        logic [N-1:0] gnt;
        int           lvl;
        logic         wr;
    } vec_t;
    vec_t tbl[22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner  = -1;
        m_beats  = 0;
        m_ptr    = 0;
        m_level  = 0;
        m_err    = 1'b0;
        m_wr     = 1'b0;
        m_wdata  = '0;
        last_acc = -1;
        m_q.delete();
    endtask

    // One clock: drive inputs, check gnt mid-cycle, then check registered outputs.
    task automatic cycle(input logic [N-1:0] r, input logic rd);
        int acc;
        int old_level;
        int idx;
        bit rel;
        bit credit;
        bit full_in;
        bit empty_in;
        bit dec;
        full_in       = (m_q.size() == FS) || force_full;
        empty_in      = (m_q.size() == 0);
        req           = r;
        fifo_rd_en    = rd;
        fifo_full     = full_in;
        fifo_empty    = empty_in;
        fifo_overflow = force_ovf;
        #1;
        acc    = -1;
        rel    = 1'b0;
        credit = (m_level < FS) && !full_in;
        if (m_owner < 0) begin
            if (credit) begin
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (acc < 0 && r[idx]) acc = idx;
                end
            end
        end else if (!r[m_owner] || m_beats == MB) begin
            rel = 1'b1;
        end else if (credit) begin
            acc = m_owner;
        end
        obs_gnt = gnt;
        chk("gnt", 32'(gnt), (acc >= 0) ? (32'd1 << acc) : 32'd0);

        @(posedge clk);
        dec       = rd && !empty_in;
        old_level = m_level;
        if (acc >= 0 && !dec) m_level++;
        else if (acc < 0 && dec && m_level > 0) m_level--;
        if (force_ovf || (full_in && old_level < FS - 1)) m_err = 1'b1;
        if (dec) void'(m_q.pop_front());
        if (m_wr) m_q.push_back(m_wdata);
        m_wr = (acc >= 0);
        if (acc >= 0) m_wdata = req_data[acc*DW +: DW];
        if (rel) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_beats = 0;
        end else if (acc >= 0) begin
            if (m_owner < 0) begin
                m_owner = acc;
                m_beats = 1;
            end else begin
                m_beats++;
            end
        end
        last_acc = acc;
        #1;
        chk("wr_en", 32'(fifo_wr_en), 32'(m_wr));
        chk("wdata", 32'(fifo_wdata), 32'(m_wdata));
        chk("level", 32'(level), 32'(m_level));
        chk("err", 32'(err), 32'(m_err));
    endtask

    task automatic do_reset();
        rst           = 1'b0;
        req           = 4'hF;
        force_full    = 1'b0;
        force_ovf     = 1'b0;
        fifo_rd_en    = 1'b0;
        fifo_full     = 1'b0;
        fifo_empty    = 1'b1;
        fifo_overflow = 1'b0;
        #2;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("rst_wdata", 32'(fifo_wdata), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        int beats;
        int n_g;
        logic [N-1:0] rq;
        logic rdr;
        n_chk = 0;
        n_err = 0;
        force_full = 1'b0;
        force_ovf  = 1'b0;
        model_reset();

        // All four requesting: four beats per owner, one idle release cycle between.
        beats = 0;
        for (int c = 0; c < 22; c++) begin
            tbl[c].req = 4'hF;
            tbl[c].rd  = 1'b0;
            tbl[c].gnt = (c / 5 < 4 && c % 5 < 4) ? 4'(4'b0001 << (c / 5)) : 4'b0000;
            if (tbl[c].gnt != 4'b0000) beats++;
            tbl[c].lvl = beats;
            tbl[c].wr  = (tbl[c].gnt != 4'b0000);
        end

        do_reset();

        // Single requester, empty FIFO.
        req_data = {8'h00, 8'h00, 8'h00, 8'hA5};
        cycle(4'b0001, 1'b0);
        chk("single_gnt", 32'(obs_gnt), 32'h1);
        chk("single_wr_en", 32'(fifo_wr_en), 32'd1);
        chk("single_wdata", 32'(fifo_wdata), 32'hA5);
        chk("single_level", 32'(level), 32'd1);

        // Round-robin bursts until full.
        do_reset();
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int c = 0; c < 22; c++) begin
            cycle(tbl[c].req, tbl[c].rd);
            chk("tbl_gnt", 32'(obs_gnt), 32'(tbl[c].gnt));
            chk("tbl_level", 32'(level), 32'(tbl[c].lvl));
            chk("tbl_wr_en", 32'(fifo_wr_en), 32'(tbl[c].wr));
        end

        // Full: a single read frees exactly one credit.
        cycle(4'hF, 1'b1);
        chk("full_rd_level", 32'(level), 32'd15);
        n_g = 0;
        for (int c = 0; c < 6; c++) begin
            cycle(4'hF, 1'b0);
            if (obs_gnt != 4'b0000) n_g++;
        end
        chk("full_one_beat", 32'(n_g), 32'd1);
        chk("full_level", 32'(level), 32'd16);
        chk("full_err", 32'(err), 32'd0);

        // Simultaneous write and read at level 8.
        do_reset();
        for (int c = 0; c < 10; c++) cycle(4'hF, 1'b0);
        chk("wr_rd_pre_level", 32'(level), 32'd8);
        cycle(4'hF, 1'b1);
        chk("wr_rd_gnt", 32'(obs_gnt), 32'h4);
        chk("wr_rd_level", 32'(level), 32'd8);
        chk("wr_rd_wr_en", 32'(fifo_wr_en), 32'd1);

        // Full flag while credit says space remains.
        force_full = 1'b1;
        cycle(4'b0000, 1'b0);
        force_full = 1'b0;
        chk("mismatch_err", 32'(err), 32'd1);
        cycle(4'b0000, 1'b0);
        chk("mismatch_sticky", 32'(err), 32'd1);

        // Overflow pulse.
        do_reset();
        force_ovf = 1'b1;
        cycle(4'b0000, 1'b0);
        force_ovf = 1'b0;
        chk("ovf_err", 32'(err), 32'd1);
        cycle(4'b0000, 1'b0);
        chk("ovf_sticky", 32'(err), 32'd1);

        // Early release: pointer moves past the owner.
        do_reset();
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        cycle(4'b0101, 1'b0);
        chk("early_g0", 32'(obs_gnt), 32'h1);
        cycle(4'b0101, 1'b0);
        chk("early_g1", 32'(obs_gnt), 32'h1);
        cycle(4'b0100, 1'b0);
        chk("early_gap", 32'(obs_gnt), 32'h0);
        cycle(4'b0101, 1'b0);
        chk("early_next", 32'(obs_gnt), 32'h4);

        // Reset in the middle of a burst.
        do_reset();
        for (int c = 0; c < 6; c++) cycle(4'hF, 1'b0);
        chk("midrst_pre_level", 32'(level), 32'd5);
        req = 4'hF;
        rst = 1'b0;
        #1;
        chk("midrst_gnt", 32'(gnt), 32'd0);
        chk("midrst_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("midrst_level", 32'(level), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        #1;
        model_reset();
        rst = 1'b1;
        cycle(4'b1000, 1'b0);
        chk("postrst_gnt", 32'(obs_gnt), 32'h8);
        chk("postrst_wr_en", 32'(fifo_wr_en), 32'd1);
        chk("postrst_wdata", 32'(fifo_wdata), 32'h13);

        // Random traffic; data only changes while idle or after a taken beat.
        rq = 4'b1000;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) rq[i] = ~rq[i];
                if (!rq[i] || last_acc == i) req_data[i*DW +: DW] = 8'($urandom);
            end
            rdr = (c < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0);
            cycle(rq, rdr);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
